// File: rtl/snake_disp_pkg.sv
// Shared constants and types for the snake tile display path.
// Pure declarations: no logic, no latency.
package snake_disp_pkg;
    localparam int COLS      = 40;
    localparam int ROWS      = 30;
    localparam int DATA_W    = 2;
    localparam int ADDR_W    = 11;
    localparam int TILE_LOG2 = 4;

    localparam logic [DATA_W-1:0] TILE_EMPTY = 2'd0;
    localparam logic [DATA_W-1:0] TILE_BODY  = 2'd1;
    localparam logic [DATA_W-1:0] TILE_HEAD  = 2'd2;
    localparam logic [DATA_W-1:0] TILE_FOOD  = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;
endpackage

// File: rtl/tile_scan_sched.sv
// Scan-out slot detector and tile address generator; purely combinational, 0 clk.
// No backpressure: slots are fixed by the sync counters and always win.
module tile_scan_sched
    import snake_disp_pkg::*;
(
    input  logic              p_tick,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    output logic              slot,
    output logic              slot_rd,
    output logic [ADDR_W-1:0] slot_addr
);
    logic       mid_slot;
    logic       eol_slot;
    logic [9:0] line;
    logic [5:0] col;
    logic [4:0] row;

    always_comb begin
        mid_slot = p_tick && (pixel_x[3:0] == 4'd8) && (pixel_x < 10'd632);
        eol_slot = p_tick && (pixel_x == 10'd792);
        slot     = mid_slot || eol_slot;

        // End-of-line slot prefetches column 0 of the following line.
        if (eol_slot) begin
            line = (pixel_y == 10'd524) ? 10'd0 : pixel_y + 10'd1;
            col  = 6'd0;
        end else begin
            line = pixel_y;
            col  = pixel_x[9:4] + 6'd1;
        end

        row       = line[8:TILE_LOG2];
        slot_rd   = slot && (line < 10'd480);
        slot_addr = ADDR_W'({row, 5'b0}) + ADDR_W'({row, 3'b0}) + ADDR_W'(col);
    end
endmodule

// File: rtl/tile_ram_arbiter.sv
// Tile RAM arbiter: scan reads (absolute priority) > clear engine > writer; RAM strobes are 0-clk.
// Writer is stalled via wr_ready in slot cycles and for the whole clear; tile_code lags its read by 15 clk.
module tile_ram_arbiter #(
    parameter int COLS   = 40,
    parameter int ROWS   = 30,
    parameter int DATA_W = 2,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_tick,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] tile_code
);
    import snake_disp_pkg::*;

    localparam int CELLS = COLS * ROWS;

    logic              slot;
    logic              slot_rd;
    logic [ADDR_W-1:0] slot_addr;

    clr_state_t        state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic              clr_wr;
    logic              clr_last;
    logic              wr_fire;
    logic              clear_done_q;
    logic              rd_pend;
    logic [DATA_W-1:0] tile_next;
    logic [DATA_W-1:0] tile_code_q;
    logic              tile_load;
    logic              tile_blank;

    tile_scan_sched u_sched (
        .p_tick    (p_tick),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .slot      (slot),
        .slot_rd   (slot_rd),
        .slot_addr (slot_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_wr      = (state == CLEAR) && !slot;
        clr_last    = clr_wr && (clr_cnt == ADDR_W'(CELLS - 1));
        wr_ready    = !slot && (state == IDLE) && !reset;
        wr_fire     = wr_valid && wr_ready;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;

        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            CLEAR: begin
                if (clr_wr) begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                    if (clr_last) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Out-of-range writer addresses complete the handshake but never reach the RAM.
        if (reset) begin
            ram_en = 1'b0;
        end else if (slot) begin
            ram_en   = slot_rd;
            ram_addr = slot_addr;
        end else if (clr_wr) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = clr_cnt;
            ram_wdata = TILE_EMPTY;
        end else if (wr_fire && (wr_addr < ADDR_W'(CELLS))) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
        end
    end

    assign tile_load  = p_tick && (((pixel_x[3:0] == 4'hF) && (pixel_x < 10'd639)) ||
                                   (pixel_x == 10'd799));
    assign tile_blank = p_tick && (pixel_x == 10'd639);

    always_ff @(posedge clk) begin
        if (reset) begin
            clear_done_q <= 1'b0;
            rd_pend      <= 1'b0;
            tile_next    <= TILE_EMPTY;
            tile_code_q  <= TILE_EMPTY;
        end else begin
            clear_done_q <= clr_last;
            rd_pend      <= slot_rd;
            // Idle slots target invisible lines, so the prefetch becomes empty.
            if (rd_pend) tile_next <= ram_rdata;
            else if (slot && !slot_rd) tile_next <= TILE_EMPTY;
            if (tile_load) tile_code_q <= tile_next;
            else if (tile_blank) tile_code_q <= TILE_EMPTY;
        end
    end

    assign clear_busy = (state == CLEAR) && !reset;
    assign clear_done = clear_done_q && !reset;
    assign tile_code  = reset ? TILE_EMPTY : tile_code_q;
endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Bench for tile_ram_arbiter: sync counter model, RAM model and a cell-level display/arbitration reference.
`timescale 1ns/1ps
module tb_tile_ram_arbiter;
    import snake_disp_pkg::*;

    localparam int NC = COLS * ROWS;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              p_tick = 1'b0;
    logic [9:0]        pixel_x = '0;
    logic [9:0]        pixel_y = '0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              clear_req = 1'b0;
    logic              clear_busy;
    logic              clear_done;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;
    logic [DATA_W-1:0] tile_code;

    always #5 clk = ~clk;

    tile_ram_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .p_tick     (p_tick),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .tile_code  (tile_code)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Physical RAM (driven by DUT strobes) and reference contents (driven by the model).
    logic [DATA_W-1:0] ram     [NC];
    logic [DATA_W-1:0] ref_mem [NC];
    int snap [int];  // displayed value per (line, column), captured when its read is due

    int px = 0, py = 0;
    bit ptk = 1'b0;
    bit zero_known = 1'b0;
    bit clearing = 1'b0;
    int clr_addr = 0;
    bit done_exp = 1'b0;
    bit req_pend = 1'b0;
    int req_addr = 0, req_data = 0;
    bit rnd_wr = 1'b0;
    bit drv_reset = 1'b1, drv_clear = 1'b0;

    bit                e_en = 0, e_we = 0, e_ref = 0, e_acc = 0, e_rst = 0;
    bit                e_cstart = 0, e_cstep = 0, e_last = 0, e_tick = 0;
    int                e_addr = 0, e_ref_addr = 0;
    logic [DATA_W-1:0] e_wdata = '0, e_ref_data = '0;
    int wr85 = 0, clr_writes = 0;

    task automatic cycle();
        bit slot, xen, xwe, xrdy, last;
        int tline, tcol, xa, key;
        logic [DATA_W-1:0] xd;
        logic [14:0] dp, ep;
        @(negedge clk);
        // Apply the effects of the cycle that just ended.
        if (e_en && e_addr < NC) begin
            if (e_we) ram[e_addr] = e_wdata;
            else ram_rdata = ram[e_addr];
        end
        if (e_ref) ref_mem[e_ref_addr] = e_ref_data;
        if (e_acc) req_pend = 1'b0;
        done_exp = e_last;
        if (e_rst) begin
            clearing = 1'b0; clr_addr = 0; done_exp = 1'b0;
            snap.delete(); zero_known = 1'b1;
        end else begin
            if (e_cstart) begin clearing = 1'b1; clr_addr = 0; end
            if (e_cstep) begin
                if (clr_addr == NC - 1) clearing = 1'b0;
                clr_addr++;
            end
        end
        if (e_tick) begin
            if (px == 639) zero_known = 1'b1;
            px = (px == 799) ? 0 : px + 1;
            if (px == 0) py = (py == 524) ? 0 : py + 1;
        end
        ptk = !ptk;
        if (rnd_wr && !req_pend && $urandom_range(0, 2) == 0) begin
            req_pend = 1'b1;
            req_addr = $urandom_range(0, NC + 15);
            req_data = $urandom_range(0, 3);
        end
        reset     = drv_reset;
        clear_req = drv_clear;
        p_tick    = ptk;
        pixel_x   = 10'(px);
        pixel_y   = 10'(py);
        wr_valid  = req_pend;
        wr_addr   = ADDR_W'(req_addr);
        wr_data   = DATA_W'(req_data);
        #1;
        slot = ptk && ((((px % 16) == 8) && (px < 632)) || (px == 792));
        xen = 0; xwe = 0; xa = 0; xd = '0; xrdy = 0; last = 0;
        e_ref = 0; e_acc = 0; e_cstep = 0; e_cstart = 0;
        if (!drv_reset) begin
            if (slot) begin
                tline = (px == 792) ? ((py == 524) ? 0 : py + 1) : py;
                tcol  = (px == 792) ? 0 : px / 16 + 1;
                if (tline < 480) begin
                    xen = 1; xa = (tline / 16) * COLS + tcol;
                    snap[tline * 64 + tcol] = int'(ref_mem[xa]);
                end else begin
                    snap[tline * 64 + tcol] = 0;
                end
            end else if (clearing) begin
                xen = 1; xwe = 1; xa = clr_addr; xd = '0;
                e_ref = 1; e_ref_addr = clr_addr; e_ref_data = '0;
                e_cstep = 1; last = (clr_addr == NC - 1);
            end else begin
                xrdy = 1;
                if (req_pend) begin
                    e_acc = 1;
                    if (req_addr < NC) begin
                        xen = 1; xwe = 1; xa = req_addr; xd = DATA_W'(req_data);
                        e_ref = 1; e_ref_addr = req_addr; e_ref_data = DATA_W'(req_data);
                    end
                end
            end
            if (!clearing && drv_clear) e_cstart = 1;
        end
        ep = {xen, xwe, ADDR_W'(xa), xd};
        dp = {ram_en, ram_en & ram_we, ram_en ? ram_addr : '0, (ram_en & ram_we) ? ram_wdata : '0};
        check("ram_port", 32'(dp), 32'(ep));
        check("wr_ready", 32'(wr_ready), 32'(xrdy));
        check("clear_busy", 32'(clear_busy), 32'(!drv_reset && clearing));
        check("clear_done", 32'(clear_done), 32'(!drv_reset && done_exp));
        if (drv_reset) begin
            check("tile_in_reset", 32'(tile_code), 0);
        end else if (px < 640) begin
            key = py * 64 + px / 16;
            if (snap.exists(key)) check("tile_code", 32'(tile_code), 32'(snap[key]));
        end else if (zero_known) begin
            check("tile_blank", 32'(tile_code), 0);
        end
        e_en = (ram_en === 1'b1); e_we = (ram_we === 1'b1);
        e_addr = int'(ram_addr); e_wdata = ram_wdata;
        e_rst = drv_reset; e_tick = ptk; e_last = last;
        if (ram_en === 1'b1 && ram_we === 1'b1 && ram_addr == 85) wr85++;
        if (clear_busy === 1'b1 && ram_en === 1'b1 && ram_we === 1'b1 && ram_wdata == 0) clr_writes++;
    endtask

    task automatic jump(input int y, input int x);
        px = x; py = y; ptk = 1'b1; e_tick = 1'b0;
        snap.delete(); zero_known = 1'b0;
    endtask

    task automatic run_to(input int y, input int x, input int budget, input string tag);
        for (int n = 0; n < budget; n++) begin
            cycle();
            if (ptk && px == x && py == y) return;
        end
        check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        bit got;
        int n;
        for (int i = 0; i < NC; i++) begin
            ram[i] = DATA_W'(i & 3);
            ref_mem[i] = DATA_W'(i & 3);
        end
        jump(0, 0);
        drv_reset = 1'b1;
        repeat (3) cycle();
        check("rst_tile", 32'(tile_code), 0);
        check("rst_wr_ready", 32'(wr_ready), 0);
        check("rst_ram_en", 32'(ram_en), 0);
        drv_reset = 1'b0;

        // Line 5 prefetch
        jump(4, 780);
        run_to(4, 792, 100, "pf792");
        check("pf792_en", 32'(ram_en), 1);
        check("pf792_addr", 32'(ram_addr), 0);
        run_to(5, 8, 100, "pf8");
        check("pf8_en", 32'(ram_en), 1);
        check("pf8_addr", 32'(ram_addr), 1);
        run_to(5, 16, 100, "pf16");
        check("pf16_tile", 32'(tile_code), 1);
        run_to(5, 640, 2000, "pf640");
        check("pf640_tile", 32'(tile_code), 0);

        // Writer held across a slot
        jump(31, 96);
        run_to(31, 103, 100, "stall");
        cycle();
        req_pend = 1'b1; req_addr = 85; req_data = 3; wr85 = 0;
        cycle();
        check("stall_rdy", 32'(wr_ready), 0);
        check("stall_rd_addr", 32'(ram_addr), 47);
        cycle();
        check("stall_acc_rdy", 32'(wr_ready), 1);
        check("stall_wr_addr", 32'(ram_addr), 85);
        run_to(32, 80, 2000, "stall_show");
        check("stall_tile", 32'(tile_code), 3);
        check("stall_wr_count", 32'(wr85), 1);

        // Out-of-range write
        req_pend = 1'b1; req_addr = NC; req_data = 1;
        cycle();
        check("oor_rdy", 32'(wr_ready), 1);
        check("oor_en", 32'(ram_en), 0);

        // Random traffic from random scan positions
        rnd_wr = 1'b1;
        for (int s = 0; s < 6; s++) begin
            jump($urandom_range(0, 524), $urandom_range(0, 799));
            repeat (2000) cycle();
        end
        rnd_wr = 1'b0;
        repeat (4) cycle();

        // Clear in active video, writer request held throughout
        jump(100, 300);
        cycle();
        drv_clear = 1'b1;
        cycle();
        drv_clear = 1'b0;
        req_pend = 1'b1; req_addr = NC - 1; req_data = 2;
        clr_writes = 0; got = 0; n = 0;
        for (int i = 0; i < 1400 && !got; i++) begin
            cycle(); n++;
            if (clear_done === 1'b1) got = 1;
        end
        check("clr_done_seen", 32'(got), 1);
        check("clr_writes", 32'(clr_writes), 1200);
        check("clr_time_ok", 32'(n <= 1241), 1);
        jump(199, 780);
        run_to(200, 400, 1000, "clr_show");
        check("clr_tile", 32'(tile_code), 0);

        // Reset in the middle of a clear, then restart
        rnd_wr = 1'b1;
        repeat (300) cycle();
        rnd_wr = 1'b0;
        repeat (4) cycle();
        jump(300, 100);
        cycle();
        drv_clear = 1'b1;
        cycle();
        drv_clear = 1'b0;
        got = 0;
        for (int i = 0; i < 1300 && !got; i++) begin
            cycle();
            if (clearing && (clr_addr + (e_cstep ? 1 : 0)) == 600) got = 1;
        end
        check("mid_clr_reached", 32'(got), 1);
        drv_reset = 1'b1;
        cycle();
        check("mid_rst_en", 32'(ram_en), 0);
        check("mid_rst_busy", 32'(clear_busy), 0);
        drv_reset = 1'b0;
        cycle();
        check("post_rst_busy", 32'(clear_busy), 0);
        check("post_rst_tile", 32'(tile_code), 0);
        check("post_rst_done", 32'(clear_done), 0);
        drv_clear = 1'b1;
        cycle();
        drv_clear = 1'b0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            cycle();
            if (ram_en === 1'b1 && ram_we === 1'b1) begin
                got = 1;
                check("restart_addr", 32'(ram_addr), 0);
            end
        end
        check("restart_seen", 32'(got), 1);
        got = 0;
        for (int i = 0; i < 1400 && !got; i++) begin
            cycle();
            if (clear_done === 1'b1) got = 1;
        end
        check("restart_done", 32'(got), 1);

        // Frame wrap and end of visible area
        rnd_wr = 1'b1;
        jump(524, 780);
        run_to(524, 792, 100, "wrap");
        check("wrap_en", 32'(ram_en), 1);
        check("wrap_addr", 32'(ram_addr), 0);
        run_to(0, 40, 200, "wrap_show");
        jump(479, 780);
        run_to(479, 792, 100, "vend");
        check("vend_en", 32'(ram_en), 0);
        check("vend_rdy", 32'(wr_ready), 0);
        run_to(480, 300, 2000, "vend_show");
        check("vend_tile", 32'(tile_code), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
